draw_rect_bounce: RTL



---
 rtl/draw_rect_bounce.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/draw_rect_bounce.sv
// Pixel-pipeline overlay stage: re-registers VGA timing and composites a solid
// rectangle that moves a fixed step per frame and bounces off the active-area edges.
module draw_rect_bounce #(
  parameter int unsigned H_ACTIVE = 800,
  parameter int unsigned V_ACTIVE = 600,
  parameter int unsigned RECT_W   = 64,
  parameter int unsigned RECT_H   = 48,
  parameter int unsigned STEP     = 2,
  parameter int unsigned X_INIT   = 0,
  parameter int unsigned Y_INIT   = 0,
  parameter logic [11:0] RECT_RGB = 12'hf0f
) (
  input  logic        pclk,
  input  logic        rst,
  input  logic        enable,
  input  logic [10:0] hcount_in,
  input  logic [10:0] vcount_in,
  input  logic        hsync_in,
  input  logic        vsync_in,
  input  logic        hblnk_in,
  input  logic        vblnk_in,
  input  logic [11:0] rgb_in,
  output logic [10:0] hcount_out,
  output logic [10:0] vcount_out,
  output logic        hsync_out,
  output logic        vsync_out,
  output logic        hblnk_out,
  output logic        vblnk_out,
  output logic [11:0] rgb_out,
  output logic        frame_tick
);

  typedef enum logic [1:0] {RIGHT_DOWN, RIGHT_UP, LEFT_DOWN, LEFT_UP} dir_t;

  dir_t        r_state, w_state_nxt;
  logic [10:0] r_x, r_y, w_x_nxt, w_y_nxt;
  logic        w_right, w_down, w_right_nxt, w_down_nxt;
  logic        r_vblnk_q, w_update;
  logic [10:0] r_hcount, r_vcount;
  logic        r_hsync, r_vsync, r_hblnk, r_vblnk, r_tick;
  logic [11:0] r_rgb, w_rgb;
  logic        w_in_x, w_in_y;

  // Vblank rising edge; r_vblnk_q resets high so a release inside vblank is not an edge.
  assign w_update = vblnk_in & ~r_vblnk_q;

  // State register (direction + position)
  always_ff @(posedge pclk or posedge rst) begin
    if (rst) begin
      r_state <= RIGHT_DOWN;
      r_x     <= 11'(X_INIT);
      r_y     <= 11'(Y_INIT);
    end else if (w_update && enable) begin
      r_state <= w_state_nxt;
      r_x     <= w_x_nxt;
      r_y     <= w_y_nxt;
    end
  end

  // Next-state: each axis steps or clamps-and-flips independently
  always_comb begin
    w_x_nxt     = r_x;
    w_y_nxt     = r_y;
    w_right_nxt = w_right;
    w_down_nxt  = w_down;
    if (w_right) begin
      if ({1'b0, r_x} + 12'(STEP) + 12'(RECT_W) >= 12'(H_ACTIVE)) begin
        w_x_nxt     = 11'(H_ACTIVE - RECT_W);
        w_right_nxt = 1'b0;
      end else begin
        w_x_nxt = r_x + 11'(STEP);
      end
    end else if (r_x <= 11'(STEP)) begin
      w_x_nxt     = '0;
      w_right_nxt = 1'b1;
    end else begin
      w_x_nxt = r_x - 11'(STEP);
    end
    if (w_down) begin
      if ({1'b0, r_y} + 12'(STEP) + 12'(RECT_H) >= 12'(V_ACTIVE)) begin
        w_y_nxt    = 11'(V_ACTIVE - RECT_H);
        w_down_nxt = 1'b0;
      end else begin
        w_y_nxt = r_y + 11'(STEP);
      end
    end else if (r_y <= 11'(STEP)) begin
      w_y_nxt    = '0;
      w_down_nxt = 1'b1;
    end else begin
      w_y_nxt = r_y - 11'(STEP);
    end
    case ({w_right_nxt, w_down_nxt})
      2'b11:   w_state_nxt = RIGHT_DOWN;
      2'b10:   w_state_nxt = RIGHT_UP;
      2'b01:   w_state_nxt = LEFT_DOWN;
      default: w_state_nxt = LEFT_UP;
    endcase
  end

  // Output decode of direction state
  always_comb begin
    w_right = (r_state == RIGHT_DOWN) || (r_state == RIGHT_UP);
    w_down  = (r_state == RIGHT_DOWN) || (r_state == LEFT_DOWN);
  end

  always_comb begin
    w_in_x = ({1'b0, hcount_in} >= {1'b0, r_x}) &&
             ({1'b0, hcount_in} <  {1'b0, r_x} + 12'(RECT_W));
    w_in_y = ({1'b0, vcount_in} >= {1'b0, r_y}) &&
             ({1'b0, vcount_in} <  {1'b0, r_y} + 12'(RECT_H));
    if (hblnk_in || vblnk_in)  w_rgb = '0;
    else if (w_in_x && w_in_y) w_rgb = RECT_RGB;
    else                       w_rgb = rgb_in;
  end

  always_ff @(posedge pclk or posedge rst) begin
    if (rst) begin
      r_hcount  <= '0;
      r_vcount  <= '0;
      r_hsync   <= 1'b0;
      r_vsync   <= 1'b0;
      r_hblnk   <= 1'b0;
      r_vblnk   <= 1'b0;
      r_rgb     <= '0;
      r_tick    <= 1'b0;
      r_vblnk_q <= 1'b1;
    end else begin
      r_hcount  <= hcount_in;
      r_vcount  <= vcount_in;
      r_hsync   <= hsync_in;
      r_vsync   <= vsync_in;
      r_hblnk   <= hblnk_in;
      r_vblnk   <= vblnk_in;
      r_rgb     <= w_rgb;
      r_tick    <= w_update;
      r_vblnk_q <= vblnk_in;
    end
  end

  assign hcount_out = r_hcount;
  assign vcount_out = r_vcount;
  assign hsync_out  = r_hsync;
  assign vsync_out  = r_vsync;
  assign hblnk_out  = r_hblnk;
  assign vblnk_out  = r_vblnk;
  assign rgb_out    = r_rgb;
  assign frame_tick = r_tick;

endmodule
